uart_fifo_flex: RTL and testbench

//  Parametrised synchronous FIFO for the UART TX/RX data paths. It replaces the fixed

---
 rtl/uart_fifo_pkg.sv | 19 +
 rtl/uart_fifo_ram.sv | 33 +++
 rtl/uart_fifo_flex.sv | 142 ++++++++++++++
 tb/tb_uart_fifo_flex.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - shared sizing helpers for the UART FIFO
// Purpose: width helper for pointer/count sizing and default geometry.
// Ports: none (package).
package uart_fifo_pkg;

  // Bits needed to hold values 0..n-1, never less than 1 so a degenerate
  // geometry still yields a legal vector.
  function automatic int clog2_safe(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  localparam int DEPTH_DEFAULT = 16;
  localparam int CNT_W = clog2_safe(DEPTH_DEFAULT + 1);
  localparam int PTR_W = clog2_safe(DEPTH_DEFAULT);

endpackage

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - simple dual-port storage for the UART FIFO
// Purpose: one synchronous write port, one asynchronous read port, no reset.
// Ports:
//   clk    in  write clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational from raddr)
module uart_fifo_ram
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int ADDR_W     = PTR_W
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_flex.sv
// rtl/uart_fifo_flex.sv - parametrised UART data-path FIFO (standard or FWFT read)
// Purpose: pointers, occupancy, status/error flags and the read output stage
// around uart_fifo_ram.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   flush               synchronous clear of pointers, count and error flags
//   wr_en, data_in      write request and data
//   rd_en               read request (FWFT: pops the head word)
//   data_out, rd_valid  read data and its qualifier
//   wr_ack              registered acknowledge of the previous cycle's write
//   full, empty         count == DEPTH / count == 0
//   almost_full/empty   count >= AF_LEVEL / count <= AE_LEVEL
//   count               current occupancy
//   overflow/underflow  sticky rejected-write / rejected-read flags
module uart_fifo_flex
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       rd_valid,
  output logic                       wr_ack,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = clog2_safe(DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  // A read on empty is rejected even if a write lands in the same cycle;
  // a write while full rides on a same-cycle read.
  assign rd_accept = rd_en & ~empty;
  assign wr_accept = wr_en & (~full | rd_accept);

  uart_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_W    (PW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_accept & ~flush),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= next_ptr(wr_ptr);
      if (rd_accept) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_accept, rd_accept})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      wr_ack <= wr_accept;
      if (wr_en & ~wr_accept) overflow  <= 1'b1;
      if (rd_en & ~rd_accept) underflow <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; forced to zero while empty so the
      // output never shows stale or uninitialised storage.
      assign data_out = empty ? '0 : ram_rdata;
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_accept;
          if (rd_accept) data_q <= ram_rdata;
        end
      end

      assign data_out = data_q;
      assign rd_valid = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_uart_fifo_flex.sv
// tb/tb_uart_fifo_flex.sv - scoreboard bench for uart_fifo_flex (DEPTH 16 standard, DEPTH 5 FWFT)
module tb_uart_fifo_flex;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] dout_a, dout_b;
  logic       rv_a, wack_a, full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic       rv_b, wack_b, full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
  logic [4:0] cnt_a;
  logic [2:0] cnt_b;

  int total = 0;
  int bad = 0;
  bit running = 1'b0;

  // Reference model: one queue per instance plus sticky/registered flag state.
  int D [2] = '{16, 5};
  int mq [2][$];
  int exp_q [$];
  bit m_ovf [2];
  bit m_udf [2];
  bit m_wack [2];
  bit m_rdv;

  always #5 clk = ~clk;

  uart_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout_a), .rd_valid(rv_a), .wr_ack(wack_a), .full(full_a), .empty(empty_a),
    .almost_full(af_a), .almost_empty(ae_a), .count(cnt_a), .overflow(ovf_a), .underflow(udf_a)
  );

  uart_fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout_b), .rd_valid(rv_b), .wr_ack(wack_b), .full(full_b), .empty(empty_b),
    .almost_full(af_b), .almost_empty(ae_b), .count(cnt_b), .overflow(ovf_b), .underflow(udf_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_ovf[i] = 1'b0;
      m_udf[i] = 1'b0;
      m_wack[i] = 1'b0;
    end
    m_rdv = 1'b0;
    exp_q.delete();
  endtask

  // Applies the FIFO rules for one clock edge using the inputs present at it.
  task automatic model_update();
    bit ra, wa;
    int v;
    if (rst || flush) begin
      model_clear();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      ra = rd_en && (mq[i].size() > 0);
      wa = wr_en && ((mq[i].size() < D[i]) || ra);
      if (ra) begin
        v = mq[i].pop_front();
        if (i == 0) exp_q.push_back(v);
      end
      if (wa) mq[i].push_back(int'(data_in));
      if (wr_en && !wa) m_ovf[i] = 1'b1;
      if (rd_en && !ra) m_udf[i] = 1'b1;
      m_wack[i] = wa;
      if (i == 0) m_rdv = ra;
    end
  endtask

  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit f);
    wr_en = w;
    rd_en = r;
    data_in = d;
    flush = f;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rst_chk(input string n, input int cnt, input int em, input int fl, input int ae,
                         input int af, input int ov, input int un, input int wa, input int rv,
                         input int dout);
    chk({n, " rst count"}, cnt, 0);
    chk({n, " rst empty"}, em, 1);
    chk({n, " rst full"}, fl, 0);
    chk({n, " rst almost_empty"}, ae, 1);
    chk({n, " rst almost_full"}, af, 0);
    chk({n, " rst overflow"}, ov, 0);
    chk({n, " rst underflow"}, un, 0);
    chk({n, " rst wr_ack"}, wa, 0);
    chk({n, " rst rd_valid"}, rv, 0);
    chk({n, " rst data_out"}, dout, 0);
  endtask

  // Asserts reset away from any clock edge and checks outputs before the next edge.
  task automatic do_rst();
    rst = 1'b1;
    #1;
    rst_chk("a", cnt_a, empty_a, full_a, ae_a, af_a, ovf_a, udf_a, wack_a, rv_a, dout_a);
    rst_chk("b", cnt_b, empty_b, full_b, ae_b, af_b, ovf_b, udf_b, wack_b, rv_b, dout_b);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_flags(input int i, input int cnt, input int fl, input int em, input int af,
                             input int ae, input int ov, input int un, input int wa, input int rv);
    int n;
    string p;
    n = mq[i].size();
    p = (i == 0) ? "a" : "b";
    chk({p, " count"}, cnt, n);
    chk({p, " full"}, fl, int'(n == D[i]));
    chk({p, " empty"}, em, int'(n == 0));
    chk({p, " almost_full"}, af, int'(n >= D[i] - 2));
    chk({p, " almost_empty"}, ae, int'(n <= 2));
    chk({p, " overflow"}, ov, int'(m_ovf[i]));
    chk({p, " underflow"}, un, int'(m_udf[i]));
    chk({p, " wr_ack"}, wa, int'(m_wack[i]));
    chk({p, " rd_valid"}, rv, (i == 0) ? int'(m_rdv) : int'(n != 0));
  endtask

  // Monitor: compares flags every cycle; pops the scoreboard whenever the
  // standard-read instance presents data, and checks the FWFT head word.
  always @(negedge clk) begin
    if (running) begin
      check_flags(0, int'(cnt_a), full_a, empty_a, af_a, ae_a, ovf_a, udf_a, wack_a, rv_a);
      check_flags(1, int'(cnt_b), full_b, empty_b, af_b, ae_b, ovf_b, udf_b, wack_b, rv_b);
      if (rv_a) begin
        chk("a scoreboard pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("a read data", int'(dout_a), exp_q.pop_front());
      end
      if (mq[1].size() != 0) chk("b head data", int'(dout_b), mq[1][0]);
    end
  end

  initial begin
    int wv [5];
    bit w, r, f;
    int pw, pr;

    running = 1'b1;
    #3;
    do_rst();

    // Fill DEPTH 16, almost_full from 14.
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 8'(k), 1'b0);
      chk("a fill count", int'(cnt_a), k + 1);
      chk("a fill almost_full", int'(af_a), int'(k + 1 >= 14));
    end
    chk("a full after 16", int'(full_a), 1);

    // Simultaneous write/read while full.
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    chk("a full wr+rd count", int'(cnt_a), 16);
    chk("a full wr+rd overflow", int'(ovf_a), 0);

    // Extra write while full is rejected.
    step(1'b1, 1'b0, 8'h77, 1'b0);
    chk("a 17th overflow", int'(ovf_a), 1);
    chk("a 17th wr_ack", int'(wack_a), 0);

    // Drain: 0x01..0x0F then 0xAA, each one cycle after rd_en.
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("a drain rd_valid", int'(rv_a), 1);
      chk("a drain data", int'(dout_a), (k < 15) ? k + 1 : 8'hAA);
    end
    chk("a empty after drain", int'(empty_a), 1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("a underflow", int'(udf_a), 1);

    // Flush at count 7 with sticky errors set.
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 8'(8'h40 + k), 1'b0);
    chk("a pre-flush count", int'(cnt_a), 7);
    chk("a pre-flush overflow", int'(ovf_a), 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("a flush count", int'(cnt_a), 0);
    chk("a flush empty", int'(empty_a), 1);
    chk("a flush overflow", int'(ovf_a), 0);

    // Simultaneous write/read on empty.
    step(1'b1, 1'b1, 8'h33, 1'b0);
    chk("a empty wr+rd count", int'(cnt_a), 1);
    chk("a empty wr+rd underflow", int'(udf_a), 1);

    // Reset in the middle of traffic.
    step(1'b1, 1'b1, 8'h12, 1'b0);
    do_rst();

    // FWFT visibility without rd_en.
    step(1'b1, 1'b0, 8'h5A, 1'b0);
    chk("b fwft rd_valid", int'(rv_b), 1);
    chk("b fwft data", int'(dout_b), 8'h5A);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("b fwft pop empty", int'(empty_b), 1);

    // DEPTH 5 wrap: three rounds of write 5 / read 5.
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int k = 0; k < 5; k++) begin
        wv[k] = int'($urandom_range(0, 255));
        step(1'b1, 1'b0, 8'(wv[k]), 1'b0);
      end
      chk("b wrap full", int'(full_b), 1);
      for (int k = 0; k < 5; k++) begin
        chk("b wrap order", int'(dout_b), wv[k]);
        step(1'b0, 1'b1, 8'h00, 1'b0);
      end
      chk("b wrap count", int'(cnt_b), 0);
    end

    // Randomised traffic with alternating bias, occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      pw = ((c / 200) % 2 == 0) ? 70 : 35;
      pr = ((c / 200) % 2 == 0) ? 35 : 70;
      w = ($urandom_range(0, 99) < pw);
      r = ($urandom_range(0, 99) < pr);
      f = ($urandom_range(0, 149) == 0);
      step(w, r, 8'($urandom_range(0, 255)), f);
      if ($urandom_range(0, 599) == 0) do_rst();
    end

    step(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
